// File: rtl/fp_addsub_sched.sv
// Round-robin scheduler that shares one multi-cycle minifloat add/sub datapath among NREQ
// requesters, sequences its stages and returns tagged results on a valid/ready port.
module fp_addsub_sched #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ),
  parameter int unsigned CNTW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*8-1:0] req_a,
  input  logic [NREQ*8-1:0] req_b,
  input  logic [NREQ-1:0]   req_op,
  output logic [7:0]        dp_a,
  output logic [7:0]        dp_b,
  output logic              dp_op,
  output logic [3:0]        dp_stage_en,
  input  logic [4:0]        dp_exc,
  input  logic [7:0]        dp_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [7:0]        rsp_result,
  output logic              rsp_exc,
  output logic [CNTW-1:0]   op_count,
  output logic [CNTW-1:0]   exc_count
);

  typedef enum logic [2:0] {StIdle, StPre, StAlign, StExec, StNorm, StResp} state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic            bubble_q, bubble_d;
  logic [7:0]      dp_a_q, dp_a_d;
  logic [7:0]      dp_b_q, dp_b_d;
  logic            dp_op_q, dp_op_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [7:0]      rsp_result_q, rsp_result_d;
  logic            rsp_exc_q, rsp_exc_d;
  logic [CNTW-1:0] op_count_q, op_count_d;
  logic [CNTW-1:0] exc_count_q, exc_count_d;

  logic            grant_found;
  logic [IDW-1:0]  grant_idx;
  logic            grant_ok;
  logic            b_sign;
  logic [7:0]      exc_result;

  // First valid requester at or above rr_ptr_q, wrapping.
  always_comb begin
    int unsigned idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(rr_ptr_q) + i) % NREQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(idx);
      end
    end
  end

  // bubble_q forces one idle cycle after every accepted response.
  assign grant_ok = (state_q == StIdle) && !bubble_q && !rst && grant_found;

  always_comb begin
    b_sign = dp_b_q[7] ^ dp_op_q;
    if (dp_exc[3] || dp_exc[2]) begin
      exc_result = 8'h78;
    end else if (dp_exc[1] && dp_exc[0] && (dp_a_q[7] != b_sign)) begin
      exc_result = 8'h78;
    end else if (dp_exc[1]) begin
      exc_result = {dp_a_q[7], 7'h70};
    end else begin
      exc_result = {b_sign, 7'h70};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      rr_ptr_q     <= '0;
      bubble_q     <= 1'b0;
      dp_a_q       <= '0;
      dp_b_q       <= '0;
      dp_op_q      <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_exc_q    <= 1'b0;
      op_count_q   <= '0;
      exc_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      bubble_q     <= bubble_d;
      dp_a_q       <= dp_a_d;
      dp_b_q       <= dp_b_d;
      dp_op_q      <= dp_op_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_exc_q    <= rsp_exc_d;
      op_count_q   <= op_count_d;
      exc_count_q  <= exc_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    bubble_d     = 1'b0;
    dp_a_d       = dp_a_q;
    dp_b_d       = dp_b_q;
    dp_op_d      = dp_op_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_exc_d    = rsp_exc_q;
    op_count_d   = op_count_q;
    exc_count_d  = exc_count_q;
    unique case (state_q)
      StIdle: begin
        if (grant_ok) begin
          state_d  = StPre;
          dp_a_d   = req_a[8*grant_idx +: 8];
          dp_b_d   = req_b[8*grant_idx +: 8];
          dp_op_d  = req_op[grant_idx];
          rsp_id_d = grant_idx;
        end
      end
      StPre: begin
        if (dp_exc[4]) begin
          state_d      = StResp;
          rsp_result_d = exc_result;
          rsp_exc_d    = 1'b1;
        end else begin
          state_d = StAlign;
        end
      end
      StAlign: state_d = StExec;
      StExec:  state_d = StNorm;
      StNorm: begin
        state_d      = StResp;
        rsp_result_d = dp_result;
        rsp_exc_d    = 1'b0;
      end
      StResp: begin
        if (rsp_ready) begin
          state_d  = StIdle;
          bubble_d = 1'b1;
          rr_ptr_d = IDW'((32'(rsp_id_q) + 32'd1) % NREQ);
          if (op_count_q != {CNTW{1'b1}}) op_count_d = op_count_q + CNTW'(1);
          if (rsp_exc_q && (exc_count_q != {CNTW{1'b1}})) begin
            exc_count_d = exc_count_q + CNTW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (grant_ok) req_ready[grant_idx] = 1'b1;
    dp_stage_en = 4'b0000;
    unique case (state_q)
      StPre:   dp_stage_en = 4'b0001;
      StAlign: dp_stage_en = 4'b0010;
      StExec:  dp_stage_en = 4'b0100;
      StNorm:  dp_stage_en = 4'b1000;
      default: dp_stage_en = 4'b0000;
    endcase
    rsp_valid = (state_q == StResp);
  end

  assign dp_a       = dp_a_q;
  assign dp_b       = dp_b_q;
  assign dp_op      = dp_op_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_exc    = rsp_exc_q;
  assign op_count   = op_count_q;
  assign exc_count  = exc_count_q;

endmodule

// File: tb/tb_fp_addsub_sched.sv
// Self-checking bench for fp_addsub_sched: directed scenarios plus random traffic, checked
// every cycle against a latency/round-robin reference model and a stand-in datapath.
module tb_fp_addsub_sched;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int CNTW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid, req_ready, req_op;
  logic [NREQ*8-1:0] req_a, req_b;
  logic [7:0]        dp_a, dp_b, dp_result, rsp_result;
  logic              dp_op, rsp_valid, rsp_ready, rsp_exc;
  logic [3:0]        dp_stage_en;
  logic [4:0]        dp_exc;
  logic [IDW-1:0]    rsp_id;
  logic [CNTW-1:0]   op_count, exc_count;

  fp_addsub_sched #(.NREQ(NREQ), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a),
    .req_b(req_b), .req_op(req_op), .dp_a(dp_a), .dp_b(dp_b), .dp_op(dp_op),
    .dp_stage_en(dp_stage_en), .dp_exc(dp_exc), .dp_result(dp_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_exc(rsp_exc), .op_count(op_count), .exc_count(exc_count)
  );

  always #5 clk = ~clk;

  function automatic logic is_nan(input logic [7:0] x);
    return (x[6:4] == 3'd7) && (x[3:0] != 4'd0);
  endfunction
  function automatic logic is_inf(input logic [7:0] x);
    return (x[6:4] == 3'd7) && (x[3:0] == 4'd0);
  endfunction
  // Stand-in arithmetic; the scheduler only forwards whatever the datapath returns.
  function automatic logic [7:0] dp_func(input logic [7:0] a, input logic [7:0] b,
                                         input logic op);
    logic [7:0] s;
    s = a + b - 8'h20;
    return op ? (a ^ ~b) : s;
  endfunction
  function automatic logic [7:0] exc_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic op);
    logic bs;
    bs = b[7] ^ op;
    if (is_nan(a) || is_nan(b)) return 8'h78;
    if (is_inf(a) && is_inf(b) && (a[7] != bs)) return 8'h78;
    if (is_inf(a)) return {a[7], 7'h70};
    return {bs, 7'h70};
  endfunction

  // Exception flags are only meaningful during prealign; junk elsewhere.
  assign dp_exc = dp_stage_en[0] ?
      {is_nan(dp_a) | is_nan(dp_b) | is_inf(dp_a) | is_inf(dp_b),
       is_nan(dp_a), is_nan(dp_b), is_inf(dp_a), is_inf(dp_b)} : 5'b01010;
  assign dp_result = dp_stage_en[3] ? dp_func(dp_a, dp_b, dp_op) : 8'hEE;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  int              cyc = 0, g_cyc = 0, n_grants = 0, m_ptr = 0, m_id = 0, k, j;
  bit              armed = 0, rst_applied = 0, m_busy = 0, m_bubble = 0, m_exc = 0, hold = 0;
  logic [7:0]      m_a, m_b, m_res;
  logic            m_op, erv;
  logic [3:0]      es;
  logic [NREQ-1:0] eg, grant_seen, last_gs;
  logic [CNTW-1:0] m_ops = '0, m_excs = '0;
  int              grant_q[$], gcyc_q[$];
  logic [7:0]      res_log[$];
  logic            exc_log[$];

  always @(negedge clk) begin
    cyc++;
    if (rst_applied) begin
      armed = 1; m_ptr = 0; m_busy = 0; m_bubble = 0; m_ops = '0; m_excs = '0;
    end
    if (armed) begin
      k = cyc - g_cyc;
      es = 4'b0000;
      erv = 1'b0;
      if (m_busy) begin
        if (m_exc) begin
          es = (k == 1) ? 4'b0001 : 4'b0000;
          erv = (k >= 2);
        end else begin
          es = (k >= 1 && k <= 4) ? 4'(1 << (k - 1)) : 4'b0000;
          erv = (k >= 5);
        end
      end
      eg = '0;
      if (!rst && !m_busy && !m_bubble) begin
        for (int i = 0; i < NREQ; i++) begin
          j = (m_ptr + i) % NREQ;
          if (eg == '0 && req_valid[j]) eg[j] = 1'b1;
        end
      end
      check("req_ready", req_ready, eg);
      check("stage_en", dp_stage_en, es);
      check("rsp_valid", rsp_valid, erv);
      check("op_count", op_count, m_ops);
      check("exc_count", exc_count, m_excs);
      if (m_busy) begin
        check("dp_a", dp_a, m_a);
        check("dp_b", dp_b, m_b);
        check("dp_op", dp_op, m_op);
      end
      if (erv) begin
        check("rsp_id", rsp_id, m_id);
        check("rsp_result", rsp_result, m_res);
        check("rsp_exc", rsp_exc, m_exc);
      end
      m_bubble = 0;
      if (erv && rsp_ready) begin
        res_log.push_back(rsp_result);
        exc_log.push_back(rsp_exc);
        m_ptr = (m_id + 1) % NREQ;
        if (m_ops != '1) m_ops++;
        if (m_exc && m_excs != '1) m_excs++;
        m_busy = 0;
        m_bubble = 1;
      end
      if (eg != '0) begin
        for (int i = 0; i < NREQ; i++) if (eg[i]) m_id = i;
        m_a = req_a[m_id*8 +: 8];
        m_b = req_b[m_id*8 +: 8];
        m_op = req_op[m_id];
        m_exc = is_nan(m_a) | is_nan(m_b) | is_inf(m_a) | is_inf(m_b);
        m_res = m_exc ? exc_ref(m_a, m_b, m_op) : dp_func(m_a, m_b, m_op);
        m_busy = 1;
        g_cyc = cyc;
        grant_seen = eg;
        n_grants++;
        grant_q.push_back(m_id);
        gcyc_q.push_back(cyc);
      end
    end
    rst_applied = rst;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    last_gs = grant_seen;
    grant_seen = '0;
    if (!hold) req_valid = req_valid & ~last_gs;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic op);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
    req_op[i] = op;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((req_valid != '0 || m_busy) && n < budget) begin
      tick();
      n++;
    end
    check("drain_timeout", (req_valid != '0 || m_busy), 0);
  endtask

  task automatic wait_grants(input int target, input int budget);
    int n = 0;
    while (grant_q.size() < target && n < budget) begin
      tick();
      n++;
    end
    check("grant_timeout", grant_q.size() < target, 0);
  endtask

  task automatic check_zero(input string p);
    check({p, "_req_ready"}, req_ready, 0);
    check({p, "_dp_a"}, dp_a, 0);
    check({p, "_dp_b"}, dp_b, 0);
    check({p, "_dp_op"}, dp_op, 0);
    check({p, "_stage_en"}, dp_stage_en, 0);
    check({p, "_rsp_valid"}, rsp_valid, 0);
    check({p, "_rsp_id"}, rsp_id, 0);
    check({p, "_rsp_result"}, rsp_result, 0);
    check({p, "_rsp_exc"}, rsp_exc, 0);
    check({p, "_op_count"}, op_count, 0);
    check({p, "_exc_count"}, exc_count, 0);
  endtask

  function automatic logic [7:0] rand_operand();
    logic [7:0] x;
    x = 8'($urandom);
    if ($urandom_range(3) == 0) x[6:4] = 3'd7;
    return x;
  endfunction

  localparam logic [7:0] EA [4] = '{8'h71, 8'h70, 8'hF0, 8'h30};
  localparam logic [7:0] EB [4] = '{8'h30, 8'h70, 8'h30, 8'h70};
  localparam logic       EO [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  localparam logic [7:0] ER [4] = '{8'h78, 8'h78, 8'hF0, 8'hF0};

  initial begin
    int base;
    rst = 1; req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1;
    grant_seen = '0;
    tick();
    tick();
    check_zero("reset");
    rst = 0;

    // Single normal add
    set_req(0, 8'h30, 8'h30, 1'b0);
    req_valid = 4'b0001;
    drain(40);
    check("t1_grants", grant_q.size(), 1);
    check("t1_id", grant_q[0], 0);
    check("t1_result", res_log[0], 8'h40);
    check("t1_exc", exc_log[0], 0);

    // All requesters held valid: strict rotation, 7-cycle spacing
    rst = 1;
    tick();
    rst = 0;
    grant_q.delete();
    gcyc_q.delete();
    for (int i = 0; i < NREQ; i++) set_req(i, 8'h30, 8'h30, 1'b0);
    hold = 1;
    req_valid = 4'hF;
    wait_grants(5, 100);
    req_valid = '0;
    hold = 0;
    drain(40);
    for (int i = 0; i < 5; i++) check("t2_order", grant_q[i], i % NREQ);
    for (int i = 1; i < 5; i++) check("t2_spacing", gcyc_q[i] - gcyc_q[i-1], 7);
    check("t2_ops", op_count, 5);

    // Exception short-circuit cases
    for (int i = 0; i < 4; i++) begin
      set_req(1, EA[i], EB[i], EO[i]);
      req_valid = 4'b0010;
      drain(20);
      check("t3_result", res_log[res_log.size()-1], ER[i]);
      check("t3_exc", exc_log[exc_log.size()-1], 1);
      if (i == 0) check("t3_exc_count", exc_count, 1);
    end
    check("t3_ops", op_count, 9);

    // Stalled response, then pointer must move past the served requester
    rsp_ready = 0;
    base = grant_q.size();
    set_req(2, 8'h30, 8'h30, 1'b0);
    set_req(3, 8'h12, 8'h34, 1'b1);
    req_valid = 4'b1100;
    wait_grants(base + 1, 20);
    set_req(2, 8'h25, 8'h41, 1'b0);
    req_valid[2] = 1'b1;
    repeat (15) tick();
    rsp_ready = 1;
    drain(60);
    check("t4_count", grant_q.size(), base + 3);
    check("t4_first", grant_q[base], 2);
    check("t4_second", grant_q[base+1], 3);
    check("t4_third", grant_q[base+2], 2);
    check("t4_ops", op_count, 12);

    // Reset while in EXEC drops the operation
    base = grant_q.size();
    set_req(0, 8'h30, 8'h30, 1'b0);
    req_valid = 4'b0001;
    wait_grants(base + 1, 20);
    tick();
    tick();
    check("t5_in_exec", dp_stage_en, 4'b0100);
    rst = 1;
    req_valid = '0;
    tick();
    check_zero("t5");
    rst = 0;
    repeat (10) tick();

    // Random traffic with random back-pressure; 4-bit counters saturate
    for (int c = 0; c < 600; c++) begin
      rsp_ready = ($urandom_range(3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(2) == 0) begin
          set_req(i, rand_operand(), rand_operand(), 1'($urandom_range(1)));
          req_valid[i] = 1'b1;
        end
      end
      tick();
    end
    req_valid = '0;
    rsp_ready = 1;
    drain(40);
    check("t6_op_sat", op_count, 4'hF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
